// File: rtl/multi_way_traffic_controller_pkg.sv
// Shared phase encodings and lamp patterns for the N-way intersection controller.
package tlc_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/multi_way_traffic_controller_rr_pick.sv
// Round-robin search: first pending way after active_way, wrapping modulo NUM_WAYS.
module tlc_rr_pick #(
    parameter int NUM_WAYS = 4,
    parameter int AW       = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] pending_i,
    input  logic [AW-1:0]       active_way_i,
    output logic [AW-1:0]       next_way_o,
    output logic                found_o
);

    logic [AW:0] sum;

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        found_o    = 1'b0;
        next_way_o = active_way_i;
        sum        = '0;
        for (int k = NUM_WAYS - 1; k >= 1; k--) begin
            sum = {1'b0, active_way_i} + (AW+1)'(k);
            if (sum >= (AW+1)'(NUM_WAYS))
                sum = sum - (AW+1)'(NUM_WAYS);
            if (pending_i[sum[AW-1:0]]) begin
                found_o    = 1'b1;
                next_way_o = sum[AW-1:0];
            end
        end
    end

endmodule

// File: rtl/multi_way_traffic_controller.sv
// N-way round-robin traffic light controller; emergency preemption when TLC_PREEMPT_EN is defined.
module multi_way_traffic_controller
    import tlc_pkg::*;
#(
    parameter int NUM_WAYS  = 4,
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 24,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 1
) (
    input  logic                        CLK,
    input  logic                        RESET,
`ifdef TLC_PREEMPT_EN
    input  logic                        preempt,
    input  logic [$clog2(NUM_WAYS)-1:0] preempt_way,
`endif
    input  logic [NUM_WAYS-1:0]         car_req,
    output logic [3*NUM_WAYS-1:0]       lights,
    output logic [$clog2(NUM_WAYS)-1:0] active_way,
    output logic [1:0]                  phase
);

    localparam int AW = $clog2(NUM_WAYS);
    localparam logic [CNT_W-1:0] T_GRN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_YEL = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] T_ALR = CNT_W'(ALLRED_T - 1);

    phase_e              phase_q;
    logic [AW-1:0]       way_q, next_q;
    logic [CNT_W-1:0]    timer_q;
    logic [NUM_WAYS-1:0] pending_q, pending_d;

    logic [NUM_WAYS-1:0] act_oh, req_eff;
    logic [AW-1:0]       pick_way, enter_way;
    logic                found, expired, enter_green;
    logic                preempt_go, preempt_hold;

    always_comb begin
        act_oh      = NUM_WAYS'(1) << way_q;
        // Same-cycle requests count so a held green yields on the very next edge.
        req_eff     = (pending_q | car_req) & ~act_oh;
        expired     = (timer_q == '0);
        enter_way   = next_q;
        preempt_go  = 1'b0;
        preempt_hold = 1'b0;
`ifdef TLC_PREEMPT_EN
        if (preempt) begin
            enter_way    = preempt_way;
            preempt_go   = (preempt_way != way_q);
            preempt_hold = (preempt_way == way_q);
        end
`endif
        enter_green = (phase_q == PH_ALLRED) && expired;
        pending_d   = pending_q | (car_req & ~((phase_q == PH_GREEN) ? act_oh : '0));
        if (enter_green)
            pending_d = pending_d & ~(NUM_WAYS'(1) << enter_way);
    end

    tlc_rr_pick #(
        .NUM_WAYS (NUM_WAYS),
        .AW       (AW)
    ) u_pick (
        .pending_i    (req_eff),
        .active_way_i (way_q),
        .next_way_o   (pick_way),
        .found_o      (found)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            phase_q   <= PH_GREEN;
            way_q     <= '0;
            next_q    <= '0;
            timer_q   <= T_GRN;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            case (phase_q)
                PH_GREEN: begin
                    if (preempt_go) begin
                        phase_q <= PH_YELLOW;
                        next_q  <= enter_way;
                        timer_q <= T_YEL;
                    end else if (!expired) begin
                        timer_q <= timer_q - 1'b1;
                    end else if (found && !preempt_hold) begin
                        phase_q <= PH_YELLOW;
                        next_q  <= pick_way;
                        timer_q <= T_YEL;
                    end
                end
                PH_YELLOW: begin
                    next_q <= enter_way;
                    if (!expired) begin
                        timer_q <= timer_q - 1'b1;
                    end else begin
                        phase_q <= PH_ALLRED;
                        timer_q <= T_ALR;
                    end
                end
                PH_ALLRED: begin
                    next_q <= enter_way;
                    if (!expired) begin
                        timer_q <= timer_q - 1'b1;
                    end else begin
                        phase_q <= PH_GREEN;
                        way_q   <= enter_way;
                        timer_q <= T_GRN;
                    end
                end
                default: begin
                    phase_q <= PH_GREEN;
                    timer_q <= T_GRN;
                end
            endcase
        end
    end

    assign phase      = phase_q;
    assign active_way = way_q;

    // Only the active way can ever leave red.
    always_comb begin
        lights = {NUM_WAYS{LAMP_RED}};
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (way_q == AW'(i)) begin
                case (phase_q)
                    PH_GREEN:  lights[3*i +: 3] = LAMP_GRN;
                    PH_YELLOW: lights[3*i +: 3] = LAMP_YEL;
                    default:   lights[3*i +: 3] = LAMP_RED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_way_traffic_controller.sv
// Directed bench for the 4-way controller with GREEN_MIN=4, YELLOW_T=2, ALLRED_T=1.
module tb_multi_way_traffic_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  car_req;
    logic [11:0] lights;
    logic [1:0]  active_way;
    logic [1:0]  phase;
`ifdef TLC_PREEMPT_EN
    logic        preempt;
    logic [1:0]  preempt_way;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    multi_way_traffic_controller #(
        .NUM_WAYS  (4),
        .CNT_W     (8),
        .GREEN_MIN (4),
        .YELLOW_T  (2),
        .ALLRED_T  (1)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
`ifdef TLC_PREEMPT_EN
        .preempt     (preempt),
        .preempt_way (preempt_way),
`endif
        .car_req     (car_req),
        .lights      (lights),
        .active_way  (active_way),
        .phase       (phase)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expected lamp word: all red except the named way in the named phase.
    function automatic logic [11:0] lamps(input logic [1:0] ph, input logic [1:0] w);
        logic [11:0] l;
        l = 12'h924;
        if (ph == 2'b00)      l[w*3 +: 3] = 3'b001;
        else if (ph == 2'b01) l[w*3 +: 3] = 3'b010;
        return l;
    endfunction

    task automatic chk_st(input string tag, input logic [1:0] ph, input logic [1:0] w);
        logic [15:0] obs, exp;
        obs = {phase, active_way, lights};
        exp = {ph, w, lamps(ph, w)};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input int n, input logic [1:0] ph, input logic [1:0] w);
        repeat (n) begin
            step();
            chk_st(tag, ph, w);
        end
    endtask

    initial begin
        RESET   = 1'b0;
        car_req = 4'b0000;
`ifdef TLC_PREEMPT_EN
        preempt     = 1'b0;
        preempt_way = 2'd0;
`endif
        #2;
        chk_st("reset_state", 2'b00, 2'd0);
        chk_val("reset_lights", lights, 12'h921);
        chk_val("reset_pending", {8'h0, dut.pending_q}, 12'h000);

        // Idle: way 0 holds green indefinitely.
        step();
        RESET = 1'b1;
        run("idle_green", 22, 2'b00, 2'd0);
        chk_val("idle_lights", lights, 12'h921);

        // One-cycle request on way 2 during way 0's first green cycle.
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        run("g0_pre", 1, 2'b00, 2'd0);
        car_req = 4'b0100;
        run("g0_pre", 1, 2'b00, 2'd0);
        car_req = 4'b0000;
        chk_val("pend_set2", {8'h0, dut.pending_q}, 12'h004);
        run("g0_tail", 1, 2'b00, 2'd0);
        run("y0", 2, 2'b01, 2'd0);
        run("ar0", 1, 2'b10, 2'd0);
        chk_val("allred_lights", lights, 12'h924);
        run("g2_enter", 1, 2'b00, 2'd2);
        chk_val("pend_clr2", {8'h0, dut.pending_q}, 12'h000);

        // Held green on way 2, then a request on way 0 wraps around.
        run("g2_hold", 5, 2'b00, 2'd2);
        car_req = 4'b0001;
        run("y2_fast", 2, 2'b01, 2'd2);
        car_req = 4'b0000;
        run("ar2", 1, 2'b10, 2'd2);
        run("g0_wrap", 1, 2'b00, 2'd0);
        chk_val("pend_clr0", {8'h0, dut.pending_q}, 12'h000);

        // Held requests on ways 1 and 3 alternate; way 2 never served.
        car_req = 4'b1010;
        run("rot_g0", 3, 2'b00, 2'd0);
        run("rot_y0", 2, 2'b01, 2'd0);
        run("rot_ar0", 1, 2'b10, 2'd0);
        run("rot_g1", 4, 2'b00, 2'd1);
        run("rot_y1", 2, 2'b01, 2'd1);
        run("rot_ar1", 1, 2'b10, 2'd1);
        run("rot_g3", 4, 2'b00, 2'd3);
        run("rot_y3", 2, 2'b01, 2'd3);
        run("rot_ar3", 1, 2'b10, 2'd3);
        run("rot_g1b", 4, 2'b00, 2'd1);
        run("rot_y1b", 1, 2'b01, 2'd1);

        // Asynchronous reset mid-yellow.
        RESET = 1'b0;
        #1;
        chk_st("rst_mid", 2'b00, 2'd0);
        chk_val("rst_mid_pend", {8'h0, dut.pending_q}, 12'h000);
        step();
        RESET   = 1'b1;
        car_req = 4'b0000;
        run("post_rst", 3, 2'b00, 2'd0);
        chk_val("post_rst_pend", {8'h0, dut.pending_q}, 12'h000);

`ifdef TLC_PREEMPT_EN
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        run("p_g0", 1, 2'b00, 2'd0);
        preempt     = 1'b1;
        preempt_way = 2'd3;
        car_req     = 4'b0010;
        run("p_y0", 2, 2'b01, 2'd0);
        run("p_ar0", 1, 2'b10, 2'd0);
        run("p_g3_hold", 8, 2'b00, 2'd3);
        preempt = 1'b0;
        run("p_y3_release", 1, 2'b01, 2'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
